// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_if #(
   parameter int unsigned REGW = 3
) ();
   logic [REGW-1:0] id_rs;
   logic [REGW-1:0] id_rt;
   logic            id_rs_used;
   logic            id_rt_used;
   logic            id_halt;
   logic [REGW-1:0] ex_rd;
   logic [REGW-1:0] mem_rd;
   logic            ex_reg_write;
   logic            mem_reg_write;
   logic            ex_mem_to_reg;
   logic            ex_branch_taken;
   logic            imem_stall;
   logic            dmem_stall;
   logic            pc_en;
   logic            ifid_en;
   logic            idex_en;
   logic            exmem_en;
   logic            memwb_en;
   logic            ifid_flush;
   logic            idex_flush;

   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used, id_halt, ex_rd, mem_rd, ex_reg_write,
             mem_reg_write, ex_mem_to_reg, ex_branch_taken, imem_stall, dmem_stall,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush
   );

   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used, id_halt, ex_rd, mem_rd, ex_reg_write,
             mem_reg_write, ex_mem_to_reg, ex_branch_taken, imem_stall, dmem_stall,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: hazard resolution, halt drain
// and saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter bit          FWD       = 1'b0,
   parameter int unsigned REGW      = 3,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   pipe_hazard_if.slave  hz_io,
   output logic          halted_o,
   output logic [15:0]   stall_cnt_o,
   output logic [15:0]   flush_cnt_o
);
   localparam int unsigned DcntW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DcntW-1:0] DcntLoad = DcntW'(DRAIN_CYC - 1);

   localparam logic [1:0] StRun    = 2'd0;
   localparam logic [1:0] StDrain  = 2'd1;
   localparam logic [1:0] StHalted = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DcntW-1:0] dcnt_q, dcnt_d;
   logic [15:0]      stall_q, stall_d;
   logic [15:0]      flush_q, flush_d;
   logic             raw;
   logic             stall_inc, flush_inc;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

   function automatic logic hit(input logic [REGW-1:0] r);
      if (FWD) begin
         // Forwarding covers everything except a load result not yet read from memory.
         return hz_io.ex_reg_write && hz_io.ex_mem_to_reg && (hz_io.ex_rd == r);
      end
      return (hz_io.ex_reg_write && (hz_io.ex_rd == r)) ||
             (hz_io.mem_reg_write && (hz_io.mem_rd == r));
   endfunction

   always_comb begin
      raw = (hz_io.id_rs_used && hit(hz_io.id_rs)) || (hz_io.id_rt_used && hit(hz_io.id_rt));
   end

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      state_d    = state_q;
      dcnt_d     = dcnt_q;
      case (state_q)
         StRun: begin
            if (hz_io.dmem_stall) begin
               stall_inc = 1'b1;
            end else if (hz_io.ex_branch_taken) begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush_inc  = 1'b1;
            end else if (raw) begin
               {idex_en, exmem_en, memwb_en} = 3'b111;
               idex_flush = 1'b1;
               stall_inc  = 1'b1;
            end else begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
               if (hz_io.imem_stall) begin
                  pc_en      = 1'b0;
                  ifid_flush = 1'b1;
                  stall_inc  = 1'b1;
               end
               if (hz_io.id_halt) begin
                  state_d = StDrain;
                  dcnt_d  = DcntLoad;
               end
            end
         end
         StDrain: begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = !hz_io.dmem_stall;
            memwb_en   = !hz_io.dmem_stall;
            if (!hz_io.dmem_stall) begin
               if (dcnt_q == '0) begin
                  state_d = StHalted;
               end else begin
                  dcnt_d = dcnt_q - 1'b1;
               end
            end
         end
         default: ;
      endcase
      // Reset forces bubbles into both front registers regardless of state.
      if (!rst_n) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      stall_d = (stall_inc && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
      flush_d = (flush_inc && (flush_q != 16'hFFFF)) ? flush_q + 16'd1 : flush_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         dcnt_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign hz_io.pc_en      = pc_en;
   assign hz_io.ifid_en    = ifid_en;
   assign hz_io.idex_en    = idex_en;
   assign hz_io.exmem_en   = exmem_en;
   assign hz_io.memwb_en   = memwb_en;
   assign hz_io.ifid_flush = ifid_flush;
   assign hz_io.idex_flush = idex_flush;
   assign halted_o         = (state_q == StHalted);
   assign stall_cnt_o      = stall_q;
   assign flush_cnt_o      = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one FWD=1 and one FWD=0 instance share clock and reset;
// per-cycle control expectations flow through a scoreboard queue.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic       exw;
      logic       ld;
      logic [2:0] exrd;
      logic       memw;
      logic [2:0] memrd;
      logic       rsu;
      logic [2:0] rs;
      logic       rtu;
      logic [2:0] rt;
      logic       br;
      logic       hlt;
      logic       im;
      logic       dm;
   } stim_t;

   typedef struct {
      bit         sel;
      logic [6:0] ctl;
      int         step;
   } exp_t;

   stim_t drv_f, drv_n;
   exp_t  exp_q[$];

   pipe_hazard_if #(.REGW(3)) if_f ();
   pipe_hazard_if #(.REGW(3)) if_n ();

   logic        halted_f, halted_n;
   logic [15:0] stall_f, stall_n, flush_f, flush_n;

   assign if_f.ex_reg_write    = drv_f.exw;
   assign if_f.ex_mem_to_reg   = drv_f.ld;
   assign if_f.ex_rd           = drv_f.exrd;
   assign if_f.mem_reg_write   = drv_f.memw;
   assign if_f.mem_rd          = drv_f.memrd;
   assign if_f.id_rs_used      = drv_f.rsu;
   assign if_f.id_rs           = drv_f.rs;
   assign if_f.id_rt_used      = drv_f.rtu;
   assign if_f.id_rt           = drv_f.rt;
   assign if_f.ex_branch_taken = drv_f.br;
   assign if_f.id_halt         = drv_f.hlt;
   assign if_f.imem_stall      = drv_f.im;
   assign if_f.dmem_stall      = drv_f.dm;

   assign if_n.ex_reg_write    = drv_n.exw;
   assign if_n.ex_mem_to_reg   = drv_n.ld;
   assign if_n.ex_rd           = drv_n.exrd;
   assign if_n.mem_reg_write   = drv_n.memw;
   assign if_n.mem_rd          = drv_n.memrd;
   assign if_n.id_rs_used      = drv_n.rsu;
   assign if_n.id_rs           = drv_n.rs;
   assign if_n.id_rt_used      = drv_n.rtu;
   assign if_n.id_rt           = drv_n.rt;
   assign if_n.ex_branch_taken = drv_n.br;
   assign if_n.id_halt         = drv_n.hlt;
   assign if_n.imem_stall      = drv_n.im;
   assign if_n.dmem_stall      = drv_n.dm;

   pipe_hazard_ctrl #(.FWD(1'b1), .REGW(3), .DRAIN_CYC(3)) u_fwd (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz_io       (if_f),
      .halted_o    (halted_f),
      .stall_cnt_o (stall_f),
      .flush_cnt_o (flush_f)
   );

   pipe_hazard_ctrl #(.FWD(1'b0), .REGW(3), .DRAIN_CYC(3)) u_nofwd (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz_io       (if_n),
      .halted_o    (halted_n),
      .stall_cnt_o (stall_n),
      .flush_cnt_o (flush_n)
   );

   // Packed as {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.
   function automatic logic [6:0] ctl_of(input bit sel);
      if (sel) begin
         return {if_f.pc_en, if_f.ifid_en, if_f.idex_en, if_f.exmem_en, if_f.memwb_en,
                 if_f.ifid_flush, if_f.idex_flush};
      end
      return {if_n.pc_en, if_n.ifid_en, if_n.idex_en, if_n.exmem_en, if_n.memwb_en,
              if_n.ifid_flush, if_n.idex_flush};
   endfunction

   task automatic idle();
      drv_f = '0;
      drv_n = '0;
   endtask

   // Applies one cycle of stimulus to the selected instance and queues its expected controls.
   task automatic drive(input bit sel, input stim_t s, input logic [6:0] exp, input int step);
      if (sel) drv_f = s;
      else     drv_n = s;
      exp_q.push_back('{sel: sel, ctl: exp, step: step});
   endtask

   function automatic stim_t mk(input logic exw, input logic ld, input logic [2:0] exrd,
                                input logic memw, input logic [2:0] memrd,
                                input logic rsu, input logic [2:0] rs,
                                input logic rtu, input logic [2:0] rt,
                                input logic br, input logic hlt, input logic im,
                                input logic dm);
      return '{exw, ld, exrd, memw, memrd, rsu, rs, rtu, rt, br, hlt, im, dm};
   endfunction

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (ctl_of(1) !== 7'b0000011 || ctl_of(0) !== 7'b0000011) begin
         errors++;
         $display("FAIL reset_ctl: got %b/%b want 0000011", ctl_of(1), ctl_of(0));
      end
      checks++;
      if ({halted_f, halted_n} !== 2'b00 || stall_f !== 16'd0 || flush_f !== 16'd0 ||
          stall_n !== 16'd0 || flush_n !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: halted %b%b stall %0d/%0d flush %0d/%0d want all 0",
                  halted_f, halted_n, stall_f, stall_n, flush_f, flush_n);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_edge();
   endtask

   task automatic test_load_use();
      exp_t        e;
      logic [15:0] base = stall_f;
      idle();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(1, mk(1, 1, 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), 7'b0011101, i);
            1:       drive(1, mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), 7'b1111100, i);
            default: drive(1, mk(1, 0, 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), 7'b1111100, i);
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (ctl_of(e.sel) !== e.ctl) begin
            errors++;
            $display("FAIL load_use step %0d: ctl got %b want %b", e.step, ctl_of(e.sel), e.ctl);
         end
         next_edge();
      end
      checks++;
      if (stall_f !== base + 16'd1) begin
         errors++;
         $display("FAIL load_use_cnt: stall_cnt got %0d want %0d", stall_f, base + 16'd1);
      end
   endtask

   task automatic test_raw_nofwd();
      exp_t        e;
      logic [15:0] base = stall_n;
      idle();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(0, mk(1, 0, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 7'b0011101, i);
            1:       drive(0, mk(0, 0, 0, 1, 3, 0, 0, 1, 3, 0, 0, 0, 0), 7'b0011101, i);
            default: drive(0, mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 7'b1111100, i);
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (ctl_of(e.sel) !== e.ctl) begin
            errors++;
            $display("FAIL raw_nofwd step %0d: ctl got %b want %b", e.step, ctl_of(e.sel), e.ctl);
         end
         next_edge();
      end
      checks++;
      if (stall_n !== base + 16'd2) begin
         errors++;
         $display("FAIL raw_nofwd_cnt: stall_cnt got %0d want %0d", stall_n, base + 16'd2);
      end
   endtask

   task automatic test_branch();
      exp_t        e;
      logic [15:0] sbase = stall_f;
      logic [15:0] fbase = flush_f;
      idle();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       drive(1, mk(1, 1, 2, 0, 0, 1, 2, 0, 0, 1, 1, 0, 0), 7'b1111111, i);
            1:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b1111100, i);
            2:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 7'b0111110, i);
            default: drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 7'b1111111, i);
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (ctl_of(e.sel) !== e.ctl) begin
            errors++;
            $display("FAIL branch step %0d: ctl got %b want %b", e.step, ctl_of(e.sel), e.ctl);
         end
         next_edge();
      end
      checks++;
      if (flush_f !== fbase + 16'd2 || stall_f !== sbase + 16'd1 || halted_f !== 1'b0) begin
         errors++;
         $display("FAIL branch_cnt: flush %0d stall %0d halted %b want %0d %0d 0",
                  flush_f, stall_f, halted_f, fbase + 16'd2, sbase + 16'd1);
      end
   endtask

   task automatic test_dmem_freeze();
      exp_t        e;
      logic [15:0] base = stall_f;
      idle();
      for (int i = 0; i < 6; i++) begin
         if (i < 4)       drive(1, mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1), 7'b0000000, i);
         else if (i == 4) drive(1, mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0), 7'b0011101, i);
         else             drive(1, mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0), 7'b1111100, i);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (ctl_of(e.sel) !== e.ctl) begin
            errors++;
            $display("FAIL dmem_freeze step %0d: ctl got %b want %b", e.step, ctl_of(e.sel),
                     e.ctl);
         end
         next_edge();
      end
      checks++;
      if (stall_f !== base + 16'd5) begin
         errors++;
         $display("FAIL dmem_freeze_cnt: stall_cnt got %0d want %0d", stall_f, base + 16'd5);
      end
   endtask

   task automatic test_halt();
      exp_t        e;
      logic [15:0] sbase = stall_f;
      logic [15:0] fbase = flush_f;
      idle();
      for (int i = 0; i < 7; i++) begin
         case (i)
            0:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b1111100, i);
            1:       drive(1, mk(1, 1, 4, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0), 7'b0111111, i);
            2:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b0110011, i);
            3:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 7'b0111111, i);
            4:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0111111, i);
            5:       drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b0000000, i);
            default: drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), 7'b0000000, i);
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (ctl_of(e.sel) !== e.ctl) begin
            errors++;
            $display("FAIL halt step %0d: ctl got %b want %b", e.step, ctl_of(e.sel), e.ctl);
         end
         next_edge();
         checks++;
         if (halted_f !== (i >= 4)) begin
            errors++;
            $display("FAIL halt_flag step %0d: halted got %b want %b", i, halted_f, (i >= 4));
         end
      end
      checks++;
      if (stall_f !== sbase || flush_f !== fbase) begin
         errors++;
         $display("FAIL halt_cnt: stall %0d flush %0d want %0d %0d", stall_f, flush_f, sbase,
                  fbase);
      end
   endtask

   task automatic test_reset_halted();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (halted_f !== 1'b0 || stall_f !== 16'd0 || flush_f !== 16'd0 ||
          ctl_of(1) !== 7'b0000011) begin
         errors++;
         $display("FAIL reset_halted: halted %b stall %0d flush %0d ctl %b want 0 0 0 0000011",
                  halted_f, stall_f, flush_f, ctl_of(1));
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_edge();
      @(negedge clk);
      checks++;
      if (ctl_of(1) !== 7'b1111100 || halted_f !== 1'b0) begin
         errors++;
         $display("FAIL reset_run: ctl got %b halted %b want 1111100 0", ctl_of(1), halted_f);
      end
      next_edge();
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      #1;
      rst_n = 1'b0;
      #2;
      test_reset();
      test_load_use();
      test_raw_nofwd();
      test_branch();
      test_dmem_freeze();
      test_halt();
      test_reset_halted();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
